scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DIV_W, default 8, width of the prescaler compare value.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 en  input  1  sequencer enable; 0 forces IDLE.
REQ-005 mode  input  1  0 = AUTO (prescaler-timed), 1 = MANUAL (step-timed).
REQ-006 step  input  1  manual advance request, sampled each cycle in MANUAL.
REQ-007 div  input  DIV_W  dwell per lane, in clocks, minus 1.
REQ-008 mask  input  4  lane enable; bit i enables lane i.
REQ-009 D0  output  1  lane index MSB, registered; drives the 2-to-4 decoder select MSB.
REQ-010 D1  output  1  lane index LSB, registered; drives the 2-to-4 decoder select LSB.
REQ-011 valid  output  1  current {D0,D1} is an enabled lane and the sequencer is active.
REQ-012 wrap  output  1  one-cycle pulse when the lane index wraps around.

Function
REQ-013 Internal lane index idx[1:0]; {D0,D1} SHALL equal idx at all times.
REQ-014 States SHALL be IDLE, AUTO and MANUAL.
REQ-015 IDLE -> AUTO (mode=0) or MANUAL (mode=1) SHALL occur when en=1 and mask!=0.
REQ-016 Any state -> IDLE SHALL occur in the cycle after en=0 or mask=0 is sampled.
REQ-017 AUTO <-> MANUAL SHALL follow mode directly; prescaler cleared on the switch; idx kept.
REQ-018 On IDLE exit, idx SHALL load the lowest-numbered enabled lane, prescaler = 0.
REQ-019 next(idx) SHALL be the first enabled lane found searching idx+1, idx+2, idx+3, idx+4 (mod 4).
REQ-020 With exactly one enabled lane, next(idx) SHALL equal idx (no change, no wrap).
REQ-021 AUTO: prescaler increments each cycle; when prescaler == div, idx <= next(idx), prescaler <= 0.
REQ-022 div = 0 SHALL advance every cycle.
REQ-023 MANUAL: step=1 SHALL advance idx <= next(idx) in the following cycle; prescaler held at 0.
REQ-024 step held high SHALL advance once per cycle (level-sensitive, no edge detect).
REQ-025 If mask[idx]=0 while AUTO/MANUAL, idx SHALL advance to next(idx) on the next edge regardless of prescaler/step; prescaler <= 0.
REQ-026 wrap SHALL be 1 for exactly the cycle after an advance where next(idx) < idx.
REQ-027 valid SHALL be 1 iff state != IDLE and mask[idx]=1 (registered state, combinational mask term).
REQ-028 In IDLE: idx, prescaler held; valid=0; wrap=0.
REQ-029 Changing div mid-dwell SHALL take effect immediately; if prescaler > new div, prescaler counts to 2^DIV_W-1, rolls to 0, then matches.

Reset
REQ-030 rst=1 at an edge SHALL set state=IDLE, idx=0, prescaler=0, wrap=0 (so D0=0, D1=0, valid=0).
REQ-031 rst SHALL take priority over all other inputs, including mid-dwell and mid-step.

Structure
REQ-032 State encoding (IDLE/AUTO/MANUAL) and NUM_LANES=4 SHALL reside in a shared package.
REQ-033 next-lane search SHALL be a combinational sub-module lane_next_find (inputs idx, mask; outputs next, wrapped).
REQ-034 Top-level outputs SHALL feed a 2-to-4 decoder without glue: D0->select MSB, D1->select LSB.

Verification
REQ-035 rst, en=1, mode=0, div=2, mask=4'b1111 -> idx 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap pulse after 3->0.
REQ-036 mask=4'b1010, div=0 -> idx 1,3,1,3 per cycle; wrap on each 3->1.
REQ-037 mode=1, mask=4'b1111, step pulses at cycles 5 and 9 -> idx 0->1 at cycle 6, 1->2 at cycle 10; no other change.
REQ-038 AUTO at idx=2, mask changed 1111->1011 -> idx=3 next edge, prescaler=0, valid low for that single cycle.
REQ-039 Mid-run rst=1 at idx=3, prescaler=1 -> next cycle D0=0, D1=0, valid=0, state IDLE.
REQ-040 mask=4'b0100, AUTO, div=1 -> idx stays 2, valid=1, wrap never asserts; en=0 -> valid=0 next cycle.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// rtl/scan_sequencer_pkg.sv - shared state encoding, lane count and lane helpers for scan_sequencer
//
// Contents:
//   NUM_LANES     number of scanned lanes (decoder outputs)
//   state_t       sequencer state encoding (IDLE / AUTO / MANUAL)
//   lowest_lane() lowest-numbered enabled lane in a mask (0 when mask is empty)
package scan_sequencer_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_MANUAL = 2'd2
  } state_t;

  function automatic logic [1:0] lowest_lane(input logic [NUM_LANES-1:0] mask);
    logic [1:0] lane;
    logic       found;
    lane  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!found && mask[i]) begin
        lane  = 2'(i);
        found = 1'b1;
      end
    end
    return lane;
  endfunction

endpackage

// File: rtl/scan_sequencer_lane_next_find.sv
// rtl/scan_sequencer_lane_next_find.sv - combinational search for the next enabled lane after idx
//
// Ports:
//   idx     [1:0] current lane index
//   mask    [3:0] lane enables
//   next    [1:0] first enabled lane among idx+1..idx+4 (mod 4); idx when mask is empty
//   wrapped       next < idx, i.e. the advance crosses lane 3 back toward lane 0
module lane_next_find
  import scan_sequencer_pkg::*;
(
  input  logic [1:0]           idx,
  input  logic [NUM_LANES-1:0] mask,
  output logic [1:0]           next,
  output logic                 wrapped
);

  logic [1:0] cand;
  logic       found;

  // Offset 4 lands back on idx itself, so a single enabled lane yields next == idx.
  always_comb begin
    next  = idx;
    cand  = idx;
    found = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = idx + 2'(k);
      if (!found && mask[cand]) begin
        next  = cand;
        found = 1'b1;
      end
    end
  end

  assign wrapped = (next < idx);

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - 4-lane scan sequencer with prescaler-timed (AUTO) or step-timed (MANUAL) advance
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   en              enable; 0 returns to IDLE
//   mode            0 = AUTO, 1 = MANUAL
//   step            manual advance request (level-sensitive)
//   div [DIV_W-1:0] dwell per lane in clocks, minus 1
//   mask [3:0]      lane enables
//   D0, D1          registered lane index MSB / LSB, straight to a 2-to-4 decoder select
//   valid           sequencer active and current lane enabled
//   wrap            one-cycle pulse after an advance that wraps the index
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 step,
  input  logic [DIV_W-1:0]     div,
  input  logic [NUM_LANES-1:0] mask,
  output logic                 D0,
  output logic                 D1,
  output logic                 valid,
  output logic                 wrap
);

  state_t           state_q, state_d, run_state;
  logic [1:0]       idx_q, idx_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             adv;
  logic [1:0]       nxt;
  logic             nxt_wrap;

  lane_next_find u_next (
    .idx     (idx_q),
    .mask    (mask),
    .next    (nxt),
    .wrapped (nxt_wrap)
  );

  assign run_state = mode ? ST_MANUAL : ST_AUTO;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    adv     = 1'b0;

    if (!en || (mask == '0)) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d = run_state;
      idx_d   = lowest_lane(mask);
      presc_d = '0;
    end else begin
      state_d = run_state;
      // A disabled current lane is skipped immediately, ahead of any mode switch or timing.
      if (!mask[idx_q]) begin
        adv     = 1'b1;
        presc_d = '0;
      end else if (state_q != run_state) begin
        presc_d = '0;
      end else if (state_q == ST_AUTO) begin
        // Equality match only: a prescaler above a newly lowered div rolls over before matching.
        if (presc_q == div) begin
          adv     = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end else begin
        presc_d = '0;
        adv     = step;
      end
    end

    if (adv) begin
      idx_d  = nxt;
      wrap_d = nxt_wrap;
    end
  end

  assign D0    = idx_q[1];
  assign D1    = idx_q[0];
  assign valid = (state_q != ST_IDLE) && mask[idx_q];
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench for scan_sequencer with directed and random stimulus
module tb_scan_sequencer;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, mode, step;
  logic [DIV_W-1:0] div;
  logic [3:0]       mask;
  logic             D0, D1, valid, wrap;

  always #5 clk = ~clk;

  scan_sequencer #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
    .div(div), .mask(mask), .D0(D0), .D1(D1), .valid(valid), .wrap(wrap)
  );

  typedef struct {
    int idx;
    bit valid;
    bit wrap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: m_run 0 = idle, 1 = running auto, 2 = running manual.
  int m_run, m_idx, m_presc;
  bit m_wrap;

  function automatic int next_lane(input int cur, input logic [3:0] mk);
    for (int k = 1; k <= 4; k++)
      if (mk[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  function automatic int first_lane(input logic [3:0] mk);
    for (int i = 0; i < 4; i++)
      if (mk[i]) return i;
    return 0;
  endfunction

  // Applies the rules to the inputs that were just sampled at the edge.
  task automatic model_edge();
    int  want_run, n;
    bit  advance;
    if (rst) begin
      m_run = 0; m_idx = 0; m_presc = 0; m_wrap = 0;
      return;
    end
    m_wrap   = 0;
    want_run = mode ? 2 : 1;
    if (!en || mask == 4'd0) begin
      m_run = 0;
      return;
    end
    if (m_run == 0) begin
      m_run = want_run; m_idx = first_lane(mask); m_presc = 0;
      return;
    end
    advance = 0;
    if (!mask[m_idx]) begin
      advance = 1; m_presc = 0;
    end else if (m_run != want_run) begin
      m_presc = 0;
    end else if (m_run == 1) begin
      if (m_presc == int'(div)) begin
        advance = 1; m_presc = 0;
      end else begin
        m_presc = (m_presc + 1) % (1 << DIV_W);
      end
    end else begin
      m_presc = 0;
      advance = step;
    end
    m_run = want_run;
    if (advance) begin
      n      = next_lane(m_idx, mask);
      m_wrap = (n < m_idx);
      m_idx  = n;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit mo, input bit s,
                       input int d, input logic [3:0] mk);
    exp_t x;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; en = e; mode = mo; step = s; div = DIV_W'(d); mask = mk;
    x.idx   = m_idx;
    x.valid = (m_run != 0) && mask[m_idx];
    x.wrap  = m_wrap;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total++;
        if (int'({D0, D1}) != x.idx) begin
          bad++;
          $display("FAIL lane t=%0t got=%0d want=%0d", $time, {D0, D1}, x.idx);
        end
        total++;
        if (valid !== x.valid) begin
          bad++;
          $display("FAIL valid t=%0t got=%0b want=%0b", $time, valid, x.valid);
        end
        total++;
        if (wrap !== x.wrap) begin
          bad++;
          $display("FAIL wrap t=%0t got=%0b want=%0b", $time, wrap, x.wrap);
        end
      end
    end
  end

  initial begin : driver
    int cur_div, guard;
    bit cur_mode;
    logic [3:0] cur_mask;
    rst = 1; en = 0; mode = 0; step = 0; div = '0; mask = 4'd0;

    // Reset then full-mask AUTO with div=2, followed by a mid-dwell reset.
    cycle(1, 0, 0, 0, 2, 4'hF);
    cycle(0, 1, 0, 0, 2, 4'hF);
    repeat (14) cycle(0, 1, 0, 0, 2, 4'hF);
    cycle(1, 1, 0, 0, 2, 4'hF);
    cycle(0, 1, 0, 0, 2, 4'hF);
    cycle(0, 1, 0, 0, 2, 4'hF);

    // Alternating lanes at div=0.
    repeat (8) cycle(0, 1, 0, 0, 0, 4'hA);

    // MANUAL with two isolated step pulses.
    cycle(0, 0, 1, 0, 0, 4'hF);
    repeat (4) cycle(0, 1, 1, 0, 0, 4'hF);
    cycle(0, 1, 1, 1, 0, 4'hF);
    repeat (3) cycle(0, 1, 1, 0, 0, 4'hF);
    cycle(0, 1, 1, 1, 0, 4'hF);
    repeat (3) cycle(0, 1, 1, 0, 0, 4'hF);
    repeat (3) cycle(0, 1, 1, 1, 0, 4'hF);

    // AUTO: drop the current lane out of the mask at idx=2.
    cycle(0, 1, 0, 0, 3, 4'hF);
    guard = 0;
    while (!(m_run == 1 && m_idx == 2 && m_presc == 1) && guard < 40) begin
      cycle(0, 1, 0, 0, 3, 4'hF);
      guard++;
    end
    repeat (6) cycle(0, 1, 0, 0, 3, 4'hB);

    // Single enabled lane, then disable.
    repeat (8) cycle(0, 1, 0, 0, 1, 4'h4);
    repeat (2) cycle(0, 0, 0, 0, 1, 4'h4);

    // Lower div below the running prescaler: roll over before the match.
    repeat (5) cycle(0, 1, 0, 0, 5, 4'hF);
    repeat (262) cycle(0, 1, 0, 0, 1, 4'hF);

    // Mode switches mid-dwell.
    repeat (3) cycle(0, 1, 0, 0, 4, 4'hF);
    repeat (3) cycle(0, 1, 1, 1, 4, 4'hF);
    repeat (7) cycle(0, 1, 0, 0, 4, 4'hF);

    // Random phase.
    cur_div = 1; cur_mode = 0; cur_mask = 4'hF;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
      if ($urandom_range(0, 39) == 0)
        cur_div = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 31) != 0, cur_mode,
            $urandom_range(0, 2) == 0, cur_div, cur_mask);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
